// File: rtl/recirc_link_ctrl.sv
// recirc_link_ctrl
//   Link-activation controller driving the data_and_active select of the
//   receive-path recirculator. A run of TRAIN_LEN consecutive valid
//   TRAIN_WORD words brings the link up (IDLE -> TRAIN -> ACTIVE). A run of
//   LOSS_LEN consecutive invalid cycles drops it through a one-cycle DRAIN
//   back to IDLE. While ACTIVE, valid non-training words are counted in a
//   saturating word_count.
//
//   Optional feature macro: RECIRC_LINK_STATS_EN
//     defined     : loss_events counts ACTIVE->DRAIN drops, saturating at 8'hFF
//     not defined : loss_events is tied to 8'h00
//
// Ports
//   clk_2f           in   block clock
//   reset            in   synchronous, active-high reset
//   link_enable      in   0 forces IDLE, 1 allows training
//   data_input       in   [DATA_W-1:0] incoming word stream
//   valid            in   data_input qualifier
//   data_and_active  out  registered select, 1 only while ACTIVE
//   link_state       out  [1:0] state code: 0 IDLE, 1 TRAIN, 2 ACTIVE, 3 DRAIN
//   word_count       out  [CNT_W-1:0] saturating payload word count
//   loss_events      out  [7:0] link-drop event counter
module recirc_link_ctrl #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] TRAIN_WORD = 32'hBCBCBCBC,
  parameter int                TRAIN_LEN  = 4,
  parameter int                LOSS_LEN   = 3,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              link_enable,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid,
  output logic              data_and_active,
  output logic [1:0]        link_state,
  output logic [CNT_W-1:0]  word_count,
  output logic [7:0]        loss_events
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [3:0] TRAIN_LEN_C = 4'(TRAIN_LEN);
  localparam logic [3:0] LOSS_LEN_C  = 4'(LOSS_LEN);

  state_t     state, state_nxt;
  logic [3:0] train_cnt, train_nxt;
  logic [3:0] loss_cnt, loss_nxt;
  logic       match;
  logic       active_nxt;
  logic       count_inc;

  assign match = valid && (data_input == TRAIN_WORD);

  // State register and counters
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state           <= IDLE;
      train_cnt       <= 4'd0;
      loss_cnt        <= 4'd0;
      data_and_active <= 1'b0;
      word_count      <= '0;
    end else begin
      state           <= state_nxt;
      train_cnt       <= train_nxt;
      loss_cnt        <= loss_nxt;
      data_and_active <= active_nxt;
      // Saturate at all-ones; stays there until reset.
      if (count_inc && (word_count != {CNT_W{1'b1}}))
        word_count <= word_count + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    train_nxt = train_cnt;
    loss_nxt  = loss_cnt;
    if (!link_enable) begin
      state_nxt = IDLE;
      train_nxt = 4'd0;
      loss_nxt  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          train_nxt = 4'd0;
          loss_nxt  = 4'd0;
          if (match) begin
            if (TRAIN_LEN_C == 4'd1) begin
              state_nxt = ACTIVE;
            end else begin
              state_nxt = TRAIN;
              train_nxt = 4'd1;
            end
          end
        end
        TRAIN: begin
          // Any gap or foreign word aborts training.
          if (match) begin
            if (train_cnt + 4'd1 == TRAIN_LEN_C) begin
              state_nxt = ACTIVE;
              train_nxt = 4'd0;
            end else begin
              train_nxt = train_cnt + 4'd1;
            end
          end else begin
            state_nxt = IDLE;
            train_nxt = 4'd0;
          end
        end
        ACTIVE: begin
          if (valid) begin
            loss_nxt = 4'd0;
          end else if (loss_cnt + 4'd1 == LOSS_LEN_C) begin
            state_nxt = DRAIN;
            loss_nxt  = 4'd0;
          end else begin
            loss_nxt = loss_cnt + 4'd1;
          end
        end
        default: begin
          // DRAIN lasts exactly one cycle; a match here is ignored.
          state_nxt = IDLE;
          train_nxt = 4'd0;
          loss_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Output logic (values registered in the state process)
  always_comb begin
    active_nxt = (state_nxt == ACTIVE);
    count_inc  = link_enable && (state == ACTIVE) && valid &&
                 (data_input != TRAIN_WORD);
  end

  assign link_state = state;

`ifdef RECIRC_LINK_STATS_EN
  logic drop_event;

  // Only a loss-driven ACTIVE->DRAIN exit counts; link_enable==0 exits do not.
  assign drop_event = link_enable && (state == ACTIVE) && (state_nxt == DRAIN);

  always_ff @(posedge clk_2f) begin
    if (reset)
      loss_events <= 8'h00;
    else if (drop_event && (loss_events != 8'hFF))
      loss_events <= loss_events + 8'h01;
  end
`else
  assign loss_events = 8'h00;
`endif

endmodule
